// File: rtl/graphics_compositor.sv
// VGA beam counters, registered sync/colour stage and game-side tick/collision helpers.
// Layer colours resolve by fixed priority (bit 0 wins) and are registered alongside sync so both leave aligned.
module graphics_compositor #(
    parameter int                      H_DISPLAY  = 640,
    parameter int                      H_FRONT    = 16,
    parameter int                      H_SYNC     = 96,
    parameter int                      H_BACK     = 48,
    parameter int                      V_DISPLAY  = 480,
    parameter int                      V_FRONT    = 10,
    parameter int                      V_SYNC     = 2,
    parameter int                      V_BACK     = 33,
    parameter bit                      SYNC_POL   = 1'b0,
    parameter int                      N_LAYERS   = 4,
    parameter logic [6*N_LAYERS-1:0]   LAYER_RGB  = {N_LAYERS{6'b111111}},
    parameter logic [5:0]              BG_RGB     = 6'b000000,
    parameter int                      CONV       = 0,
    parameter int                      TICK_DIV   = 3,
    parameter int                      STROBE_BIT = 5,
    parameter int                      COLL_A     = 0,
    parameter int                      COLL_B     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_LAYERS-1:0] i_layer,
    output logic [9-CONV:0]     o_hpos,
    output logic [9-CONV:0]     o_vpos,
    output logic                o_hsync,
    output logic                o_vsync,
    output logic [1:0]          o_red,
    output logic [1:0]          o_green,
    output logic [1:0]          o_blue,
    output logic                o_display_on,
    output logic                o_frame_tick,
    output logic                o_game_tick,
    output logic                o_game_tick_r,
    output logic                o_vstrobe,
    output logic                o_collision,
    output logic                o_collision_frame
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [3:0] TICK_LAST = 4'(TICK_DIV - 1);

    logic [9:0] hpos_reg, vpos_reg;
    logic [3:0] frame_cnt_reg;
    logic       vbit_reg, coll_acc_reg, coll_frame_reg, game_tick_r_reg;
    logic       hsync_reg, vsync_reg, display_reg;
    logic [5:0] pix_reg, pix_next;
    logic       hsync_raw, vsync_raw, display_on, coll_visible;
    logic [5:0] layer_rgb [N_LAYERS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_reg <= '0;
            vpos_reg <= '0;
        end else if (hpos_reg == H_LAST) begin
            hpos_reg <= '0;
            vpos_reg <= (vpos_reg == V_LAST) ? 10'd0 : vpos_reg + 10'd1;
        end else begin
            hpos_reg <= hpos_reg + 10'd1;
        end
    end

    assign hsync_raw  = (hpos_reg >= HS_START) && (hpos_reg <= HS_END);
    assign vsync_raw  = (vpos_reg >= VS_START) && (vpos_reg <= VS_END);
    assign display_on = (hpos_reg < H_VIS) && (vpos_reg < V_VIS);

    genvar gi;
    generate
        for (gi = 0; gi < N_LAYERS; gi++) begin : g_layer
            assign layer_rgb[gi] = LAYER_RGB[6*gi +: 6];
        end
    endgenerate

    // Walk from lowest to highest priority so the lowest set index overwrites last.
    always_comb begin
        pix_next = BG_RGB;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (i_layer[i]) pix_next = layer_rgb[i];
        end
        if (!display_on) pix_next = 6'b000000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_reg   <= !SYNC_POL;
            vsync_reg   <= !SYNC_POL;
            display_reg <= 1'b0;
            pix_reg     <= '0;
        end else begin
            hsync_reg   <= hsync_raw ? SYNC_POL : !SYNC_POL;
            vsync_reg   <= vsync_raw ? SYNC_POL : !SYNC_POL;
            display_reg <= display_on;
            pix_reg     <= pix_next;
        end
    end

    assign o_frame_tick = (hpos_reg == 10'd0) && (vpos_reg == 10'd0);
    assign o_game_tick  = o_frame_tick && (frame_cnt_reg == TICK_LAST);
    assign o_vstrobe    = vpos_reg[STROBE_BIT] && !vbit_reg;
    assign o_collision  = i_layer[COLL_A] && i_layer[COLL_B];
    assign coll_visible = o_collision && display_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg   <= '0;
            game_tick_r_reg <= 1'b0;
            vbit_reg        <= 1'b0;
            coll_acc_reg    <= 1'b0;
            coll_frame_reg  <= 1'b0;
        end else begin
            game_tick_r_reg <= o_game_tick;
            vbit_reg        <= vpos_reg[STROBE_BIT];
            if (o_frame_tick) begin
                frame_cnt_reg  <= (frame_cnt_reg == TICK_LAST) ? 4'd0 : frame_cnt_reg + 4'd1;
                // A hit on the tick cycle itself still belongs to the frame that is ending.
                coll_frame_reg <= coll_acc_reg || coll_visible;
                coll_acc_reg   <= 1'b0;
            end else if (coll_visible) begin
                coll_acc_reg   <= 1'b1;
            end
        end
    end

    assign o_hpos            = hpos_reg[9:CONV];
    assign o_vpos            = vpos_reg[9:CONV];
    assign o_hsync           = hsync_reg;
    assign o_vsync           = vsync_reg;
    assign o_red             = pix_reg[5:4];
    assign o_green           = pix_reg[3:2];
    assign o_blue            = pix_reg[1:0];
    assign o_display_on      = display_reg;
    assign o_game_tick_r     = game_tick_r_reg;
    assign o_collision_frame = coll_frame_reg;

endmodule

// File: tb/tb_graphics_compositor.sv
module tb_graphics_compositor;

    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NL-1:0] i_layer = '0;
    logic [9:0]    o_hpos, o_vpos;
    logic          o_hsync, o_vsync, o_display_on;
    logic [1:0]    o_red, o_green, o_blue;
    logic          o_frame_tick, o_game_tick, o_game_tick_r, o_vstrobe;
    logic          o_collision, o_collision_frame;

    graphics_compositor #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .SYNC_POL(1'b0), .N_LAYERS(NL),
        .LAYER_RGB({6'b010101, 6'b000011, 6'b001100, 6'b110000}),
        .BG_RGB(6'b000001), .CONV(0), .TICK_DIV(3), .STROBE_BIT(2),
        .COLL_A(0), .COLL_B(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_layer(i_layer),
        .o_hpos(o_hpos), .o_vpos(o_vpos), .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_display_on(o_display_on), .o_frame_tick(o_frame_tick),
        .o_game_tick(o_game_tick), .o_game_tick_r(o_game_tick_r),
        .o_vstrobe(o_vstrobe), .o_collision(o_collision),
        .o_collision_frame(o_collision_frame)
    );

    always #5 clk = ~clk;

    typedef enum int { S_HPOS, S_VPOS, S_HSYNC, S_VSYNC, S_RGB, S_DISP, S_FT,
                       S_GT, S_GTR, S_VS, S_COLL, S_CF } sig_e;
    typedef struct { int ep; int cyc; sig_e sig; int exp; } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   fails   = 0;
    int   stim_cyc = 0;

    task automatic expect_at(input int ep, input int c, input sig_e s, input int v);
        exp_t e;
        e.ep = ep; e.cyc = c; e.sig = s; e.exp = v;
        sb.push_back(e);
    endtask

    function automatic int sample(input sig_e s);
        case (s)
            S_HPOS:  return int'(o_hpos);
            S_VPOS:  return int'(o_vpos);
            S_HSYNC: return int'(o_hsync);
            S_VSYNC: return int'(o_vsync);
            S_RGB:   return int'({o_red, o_green, o_blue});
            S_DISP:  return int'(o_display_on);
            S_FT:    return int'(o_frame_tick);
            S_GT:    return int'(o_game_tick);
            S_GTR:   return int'(o_game_tick_r);
            S_VS:    return int'(o_vstrobe);
            S_COLL:  return int'(o_collision);
            default: return int'(o_collision_frame);
        endcase
    endfunction

    initial begin
        int  mon_epoch = 0;
        int  mon_cyc = -1;
        bit  prev_rst = 1'b0;
        int  act;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (prev_rst) mon_epoch++;
                mon_cyc = -1;
            end else if (!prev_rst) begin
                mon_cyc = 0;
            end else begin
                mon_cyc++;
            end
            prev_rst = rst_n;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].ep == mon_epoch && sb[i].cyc == mon_cyc) begin
                    act = sample(sb[i].sig);
                    vectors++;
                    if (act !== sb[i].exp) begin
                        fails++;
                        $display("FAIL %s ep%0d cyc%0d: got %0d, want %0d",
                                 sb[i].sig.name(), sb[i].ep, sb[i].cyc, act, sb[i].exp);
                    end else begin
                        $display("ok   %s ep%0d cyc%0d = %0d",
                                 sb[i].sig.name(), sb[i].ep, sb[i].cyc, act);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    task automatic goto(input int k);
        while (stim_cyc < k) begin
            @(posedge clk);
            #1;
            stim_cyc++;
        end
    endtask

    task automatic expect_reset_state(input int ep);
        expect_at(ep, -1, S_HSYNC, 1); expect_at(ep, -1, S_VSYNC, 1);
        expect_at(ep, -1, S_RGB, 0);   expect_at(ep, -1, S_DISP, 0);
        expect_at(ep, -1, S_GTR, 0);   expect_at(ep, -1, S_CF, 0);
        expect_at(ep, -1, S_HPOS, 0);  expect_at(ep, -1, S_VPOS, 0);
    endtask

    initial begin
        expect_reset_state(0);
        expect_at(0, 0, S_FT, 1);    expect_at(0, 0, S_GT, 0);    expect_at(0, 0, S_VS, 0);
        expect_at(0, 0, S_HSYNC, 1); expect_at(0, 0, S_DISP, 0);
        expect_at(0, 1, S_FT, 0);    expect_at(0, 1, S_DISP, 1);  expect_at(0, 1, S_RGB, 1);
        expect_at(0, 16, S_DISP, 1); expect_at(0, 17, S_DISP, 0);
        expect_at(0, 18, S_HSYNC, 1); expect_at(0, 19, S_HSYNC, 0);
        expect_at(0, 21, S_HSYNC, 0); expect_at(0, 22, S_HSYNC, 1);
        expect_at(0, 23, S_HPOS, 23); expect_at(0, 23, S_VPOS, 0);
        expect_at(0, 24, S_HPOS, 0);  expect_at(0, 24, S_VPOS, 1);
        expect_at(0, 407, S_HPOS, 23); expect_at(0, 407, S_VPOS, 16);
        expect_at(0, 35, S_RGB, 48); expect_at(0, 36, S_RGB, 3);
        expect_at(0, 37, S_RGB, 21); expect_at(0, 38, S_RGB, 1);
        expect_at(0, 39, S_RGB, 48); expect_at(0, 40, S_RGB, 1);
        expect_at(0, 41, S_RGB, 0);  expect_at(0, 41, S_DISP, 0);
        expect_at(0, 38, S_COLL, 0); expect_at(0, 40, S_COLL, 1); expect_at(0, 41, S_COLL, 0);
        expect_at(0, 95, S_VS, 0);  expect_at(0, 96, S_VS, 1);  expect_at(0, 97, S_VS, 0);
        expect_at(0, 288, S_VS, 1); expect_at(0, 408, S_VS, 0); expect_at(0, 504, S_VS, 1);
        expect_at(0, 312, S_VSYNC, 1); expect_at(0, 313, S_VSYNC, 0);
        expect_at(0, 360, S_VSYNC, 0); expect_at(0, 361, S_VSYNC, 1);
        expect_at(0, 408, S_FT, 1);  expect_at(0, 408, S_GT, 0);
        expect_at(0, 816, S_GT, 1);  expect_at(0, 817, S_GT, 0);
        expect_at(0, 817, S_GTR, 1); expect_at(0, 818, S_GTR, 0);
        expect_at(0, 1224, S_GT, 0); expect_at(0, 1632, S_GT, 0);
        expect_at(0, 409, S_CF, 0);
        expect_at(0, 461, S_COLL, 1); expect_at(0, 462, S_COLL, 0);
        expect_at(0, 462, S_CF, 0);  expect_at(0, 816, S_CF, 0);
        expect_at(0, 817, S_CF, 1);  expect_at(0, 1000, S_CF, 1); expect_at(0, 1224, S_CF, 1);
        expect_at(0, 1225, S_CF, 1); expect_at(0, 1633, S_CF, 0); expect_at(0, 1700, S_CF, 0);
        expect_at(0, 1771, S_HSYNC, 0);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        stim_cyc = 0;

        goto(34);  i_layer = 4'b0101;
        goto(35);  i_layer = 4'b0100;
        goto(36);  i_layer = 4'b1000;
        goto(37);  i_layer = 4'b0000;
        goto(38);  i_layer = 4'b1101;
        goto(39);  i_layer = 4'b0000;
        goto(40);  i_layer = 4'b0011;
        goto(41);  i_layer = 4'b0000;
        goto(461); i_layer = 4'b0011;
        goto(462); i_layer = 4'b0000;
        goto(1224); i_layer = 4'b0011;
        goto(1225); i_layer = 4'b0000;
        goto(1755); i_layer = 4'b0011;
        goto(1756); i_layer = 4'b0000;

        expect_reset_state(1);
        expect_at(1, 0, S_FT, 1);   expect_at(1, 0, S_GT, 0);   expect_at(1, 0, S_HSYNC, 1);
        expect_at(1, 1, S_CF, 0);   expect_at(1, 1, S_DISP, 1);
        expect_at(1, 408, S_GT, 0); expect_at(1, 409, S_CF, 0); expect_at(1, 816, S_GT, 1);
        goto(1772);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (o_hpos !== 10'd0 || o_vpos !== 10'd0) begin
            fails++;
            $display("FAIL async reset pos: got h%0d v%0d, want 0 0", o_hpos, o_vpos);
        end else begin
            $display("ok   async reset pos = 0 0");
        end
        vectors++;
        if (o_hsync !== 1'b1) begin
            fails++;
            $display("FAIL async reset hsync: got %0d, want 1", o_hsync);
        end else begin
            $display("ok   async reset hsync = 1");
        end
        vectors++;
        if (o_vsync !== 1'b1) begin
            fails++;
            $display("FAIL async reset vsync: got %0d, want 1", o_vsync);
        end else begin
            $display("ok   async reset vsync = 1");
        end
        vectors++;
        if ({o_red, o_green, o_blue} !== 6'd0 || o_display_on !== 1'b0) begin
            fails++;
            $display("FAIL async reset rgb/disp: got %0d/%0d, want 0/0",
                     {o_red, o_green, o_blue}, o_display_on);
        end else begin
            $display("ok   async reset rgb/disp = 0/0");
        end
        vectors++;
        if (o_collision_frame !== 1'b0 || o_game_tick_r !== 1'b0) begin
            fails++;
            $display("FAIL async reset cf/gtr: got %0d/%0d, want 0/0",
                     o_collision_frame, o_game_tick_r);
        end else begin
            $display("ok   async reset cf/gtr = 0/0");
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        stim_cyc = 0;
        goto(820);
        repeat (3) @(posedge clk);

        foreach (sb[i]) begin
            vectors++;
            fails++;
            $display("FAIL %s ep%0d cyc%0d: never checked, want %0d",
                     sb[i].sig.name(), sb[i].ep, sb[i].cyc, sb[i].exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/graphics_compositor.md
# graphics_compositor

Parametrised VGA timing generator and layer compositor for the game display path. Generates sync and beam position with configurable geometry and polarity. Resolves N prioritised colour layers into a 6-bit RGB pixel with sync and colour registered in the same stage, so they stay aligned. Produces frame, game-rate and row-strobe ticks, plus per-pixel and per-frame collision flags for the game logic.

## Interface
Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- SYNC_POL, 0, active sync level (0 = active-low)
- N_LAYERS, 4, number of colour layers (1..8)
- LAYER_RGB, all 6'b111111, packed {r,g,b} per layer, 6*N_LAYERS bits, layer i at [6*i +: 6]
- BG_RGB, 6'b000000, colour when no layer is hit inside the display area
- CONV, 0, low position bits dropped on o_hpos/o_vpos
- TICK_DIV, 3, frames per game tick (1..16)
- STROBE_BIT, 5, vpos bit whose rising edge drives o_vstrobe
- COLL_A, 0, first collision layer index
- COLL_B, 1, second collision layer index

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- i_layer  in  N_LAYERS  layer hit for the current o_hpos/o_vpos; bit 0 is highest priority
- o_hpos  out  10-CONV  hpos[9:CONV], combinational from counter
- o_vpos  out  10-CONV  vpos[9:CONV], combinational from counter
- o_hsync  out  1  registered horizontal sync
- o_vsync  out  1  registered vertical sync
- o_red, o_green, o_blue  out  2 each  registered pixel colour
- o_display_on  out  1  registered active-video flag
- o_frame_tick  out  1  1-cycle pulse at hpos==0 && vpos==0
- o_game_tick  out  1  1-cycle pulse every TICK_DIV-th frame tick
- o_game_tick_r  out  1  o_game_tick delayed one cycle
- o_vstrobe  out  1  1-cycle pulse on rising edge of vpos[STROBE_BIT]
- o_collision  out  1  combinational: i_layer[COLL_A] && i_layer[COLL_B]
- o_collision_frame  out  1  registered: collision seen in the previous complete frame

## Operation
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL is the vertical sum (default 525).
- hpos counts 0..H_TOTAL-1.
  - At H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps to 0 when it is V_TOTAL-1 and hpos wraps.
- Raw sync, defined on the current counters:
  - hsync is active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
  - vsync is active for vpos in the equivalent range.
  - display_on = hpos<H_DISPLAY && vpos<V_DISPLAY.
- Colour selection, evaluated each cycle and then registered:
  - if !display_on: 0;
  - else the lowest index i with i_layer[i] selects LAYER_RGB[6*i +: 6];
  - else BG_RGB.
  - Bits [5:4]=red, [3:2]=green, [1:0]=blue.
- Game tick:
  - frame_cnt runs 0..TICK_DIV-1 and advances on o_frame_tick, wrapping to 0.
  - o_game_tick = o_frame_tick && frame_cnt==TICK_DIV-1.
- Row strobe: vbit_r registers vpos[STROBE_BIT]; o_vstrobe = vpos[STROBE_BIT] && !vbit_r.
- Collision per frame:
  - coll_acc is set in any cycle with o_collision && display_on.
  - On o_frame_tick, o_collision_frame <= coll_acc (including that cycle's contribution) and coll_acc clears.
  - o_collision_frame therefore holds steady for a whole frame.

## Timing
- Reset (rst_n low, asynchronous):
  - hpos=vpos=0, frame_cnt=0, coll_acc=0, vbit_r=0.
  - o_hsync/o_vsync inactive (!SYNC_POL); RGB=0; o_display_on=0.
  - o_game_tick_r=0; o_collision_frame=0.
- The first cycle after release is hpos=vpos=0, so o_frame_tick=1. Because frame_cnt=0 on that cycle, no game tick fires unless TICK_DIV=1.
- Pipeline latency:
  - i_layer sampled in cycle t appears on RGB at t+1.
  - hsync/vsync/display_on computed in cycle t appear at t+1.
  - Colour and sync are aligned exactly.
- o_frame_tick, o_game_tick, o_vstrobe and o_collision are combinational in the counter cycle, with no pipeline delay.
- Simultaneous frame tick and collision in the same cycle: the collision counts toward the ending frame.
- rst_n asserted mid-frame: all state returns to reset values immediately; accumulated collision is discarded.

## Test plan
- Reset release, default parameters:
  - cycle 0 gives o_frame_tick=1, o_game_tick=0.
  - o_game_tick first pulses on the 3rd frame tick (cycle 2*420000), then every 420000 cycles.
- Line timing:
  - raw hsync is active for hpos 656..751, so o_hsync=0 (active-low) on cycles 657..752 of each line.
  - o_vsync=0 while the registered vpos is 490..491.
- Priority:
  - LAYER_RGB layer0=6'b110000, layer2=6'b000011; drive i_layer=4'b0101 at hpos=10, vpos=10.
  - Next cycle RGB=r11 g00 b00. With i_layer=0 the output is BG_RGB. At hpos=700 the output is 0.
- Collision:
  - assert i_layer bits 0 and 1 for one visible cycle in frame N.
  - o_collision=1 that cycle only; o_collision_frame=1 throughout frame N+1 and returns to 0 in frame N+2.
- Row strobe:
  - o_vstrobe pulses at hpos=0 on vpos=32, 96, 160, … (one cycle each).
  - No pulse at vpos wrap 524->0.
- Mid-frame reset at hpos=300, vpos=200 with coll_acc set:
  - outputs return to reset values immediately.
  - o_collision_frame stays 0 at the next frame tick.
